// File: rtl/lfsr_descrambler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr_descrambler_pkg : shared types and constants for descrambler  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lfsr_descrambler_pkg;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;
  localparam int          KEY_BITS     = 32;
  localparam int          CNT_W        = $clog2(KEY_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr_descrambler_32bit_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keystream_lfsr32 : 32-bit Galois LFSR, one keystream bit per step  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module keystream_lfsr32
  import lfsr_descrambler_pkg::*;
#(
  parameter logic [31:0] POLY = DEFAULT_POLY,
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic        key_bit,
  output logic [31:0] state
);

  logic [31:0] r_lfsr;
  logic [31:0] w_stepped;

  // A zero state would lock the register, so a zero seed falls back to SEED.
  assign w_stepped = {r_lfsr[30:0], 1'b0} ^ (r_lfsr[31] ? POLY : 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (load) begin
      r_lfsr <= (seed == 32'h0) ? SEED : seed;
    end else if (step) begin
      r_lfsr <= w_stepped;
    end
  end

  assign key_bit = r_lfsr[31];
  assign state   = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/lfsr_descrambler_32bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr_descrambler_32bit : serial-keystream 32-bit word descrambler  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lfsr_descrambler_32bit
  import lfsr_descrambler_pkg::*;
#(
  parameter logic [31:0] POLY = DEFAULT_POLY,
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [KEY_BITS-1:0] r_key;
  logic [KEY_BITS-1:0] r_data;
  logic [KEY_BITS-1:0] r_out_data;
  logic [KEY_BITS-1:0] w_key_nxt;
  logic [KEY_BITS-1:0] w_out_nxt;
  logic [31:0]         w_lfsr_state;
  logic                w_key_bit;
  logic                w_load;
  logic                w_step;
  logic                w_accept;
  logic                w_last;

  assign w_load    = (r_state == IDLE) && seed_load;
  assign w_accept  = (r_state == IDLE) && !seed_load && in_valid;
  assign w_step    = (r_state == GEN);
  assign w_last    = w_step && (r_cnt == CNT_W'(KEY_BITS - 1));
  assign w_key_nxt = {r_key[KEY_BITS-2:0], w_key_bit};

  keystream_lfsr32 #(
    .POLY (POLY),
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .seed    (seed_in),
    .step    (w_step),
    .key_bit (w_key_bit),
    .state   (w_lfsr_state)
  );

  // Output word combines the captured word with the key including this cycle's bit.
  genvar gi;
  generate
    for (gi = 0; gi < KEY_BITS; gi++) begin : g_xor
      assign w_out_nxt[gi] = r_data[gi] ^ w_key_nxt[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !seed_load;
        if (w_accept) begin
          w_state_nxt = GEN;
        end
      end
      GEN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_key      <= '0;
      r_data     <= '0;
      r_out_data <= '0;
    end else begin
      if (w_accept) begin
        r_cnt  <= '0;
        r_key  <= '0;
        r_data <= in_data;
      end else if (w_step) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_key <= w_key_nxt;
      end
      if (w_last) begin
        r_out_data <= w_out_nxt;
      end
    end
  end

  assign out_data = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_descrambler_32bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lfsr_descrambler_32bit : directed self-checking bench           |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lfsr_descrambler_32bit;

  localparam logic [31:0] C_POLY = 32'h04C11DB7;
  localparam logic [31:0] C_SEED = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [31:0] seed_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_lfsr;

  always #5 clk = ~clk;

  lfsr_descrambler_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Next 32 keystream bits from the reference LFSR, first bit in the MSB.
  task automatic model_key(output logic [31:0] k);
    logic b;
    k = 32'h0;
    for (int i = 0; i < 32; i++) begin
      b      = m_lfsr[31];
      m_lfsr = {m_lfsr[30:0], 1'b0} ^ (b ? C_POLY : 32'h0);
      k      = {k[30:0], b};
    end
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    #1 chk("in_ready_during_load", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr    = (s == 32'h0) ? C_SEED : s;
  endtask

  task automatic accept(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    #1 chk("in_ready_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", 32'(n), 32'd32);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_release", 32'(out_valid), 32'd0);
    chk("in_ready_after_release", 32'(in_ready), 32'd1);
    chk("busy_after_release", 32'(busy), 32'd0);
  endtask

  task automatic run_word(input logic [31:0] d, output logic [31:0] got);
    accept(d);
    wait_out();
    got = out_data;
    release_out();
  endtask

  initial begin
    logic [31:0] k, got, w, d;
    rst_n     = 1'b0;
    seed_load = 1'b0;
    seed_in   = 32'h0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    m_lfsr    = C_SEED;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_lfsr", dut.w_lfsr_state, C_SEED);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(negedge clk);

    // seed 1: 31 zero bits then a one; state lands exactly on POLY
    load_seed(32'h00000001);
    run_word(32'hDEADBEEF, got);
    chk("seed1_out", got, 32'hDEADBEEE);
    chk("seed1_lfsr", dut.w_lfsr_state, 32'h04C11DB7);
    model_key(k);

    // zero seed falls back to the default
    load_seed(32'h0);
    chk("zero_seed_lfsr", dut.w_lfsr_state, C_SEED);
    model_key(k);
    run_word(32'h0, got);
    chk("zero_seed_key", got, k);
    chk("lfsr_nonzero", 32'(dut.w_lfsr_state != 32'h0), 32'd1);

    // round trip over a continuous keystream
    load_seed(32'h12345678);
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      model_key(k);
      run_word(w ^ k, got);
      chk("round_trip", got, w);
    end
    chk("lfsr_continuous", dut.w_lfsr_state, m_lfsr);

    // backpressure in HOLD with distracting inputs
    d = 32'hA5A5C3C3;
    model_key(k);
    accept(d);
    wait_out();
    chk("bp_first", out_data, d ^ k);
    in_valid  = 1'b1;
    in_data   = 32'hFFFF0000;
    seed_load = 1'b1;
    seed_in   = 32'h00000055;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", out_data, d ^ k);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    seed_load = 1'b0;
    chk("bp_lfsr_kept", dut.w_lfsr_state, m_lfsr);
    release_out();

    // simultaneous seed_load and in_valid: load wins, word taken next cycle
    d         = 32'h0BADC0DE;
    seed_load = 1'b1;
    seed_in   = 32'hCAFEF00D;
    in_valid  = 1'b1;
    in_data   = d;
    #1 chk("sim_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr    = 32'hCAFEF00D;
    chk("sim_not_accepted", 32'(busy), 32'd0);
    chk("sim_lfsr", dut.w_lfsr_state, 32'hCAFEF00D);
    model_key(k);
    run_word(d, got);
    chk("sim_out", got, d ^ k);

    // reset at counter 15
    d = 32'h13579BDF;
    accept(d);
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_gen_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("gen_rst_out_valid", 32'(out_valid), 32'd0);
    chk("gen_rst_busy", 32'(busy), 32'd0);
    chk("gen_rst_lfsr", dut.w_lfsr_state, C_SEED);
    @(negedge clk);
    rst_n  = 1'b1;
    m_lfsr = C_SEED;
    model_key(k);
    run_word(d, got);
    chk("post_rst_out", got, d ^ k);

    // reset while holding a result
    accept(32'h2468ACE0);
    wait_out();
    rst_n = 1'b0;
    #1;
    chk("hold_rst_out_valid", 32'(out_valid), 32'd0);
    chk("hold_rst_out_data", out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
